// File: rtl/alu_adder_hold.sv
// alu_adder_hold: 6502 ALU core with its adder hold register.
// Binary operations (SUM/AND/OR/EOR/SR) complete in the start cycle.
// A decimal-mode SUM parks the binary result internally and applies the
// BCD add/subtract correction one cycle later, publishing only the
// corrected value.
module alu_adder_hold (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a_IN,
    input  logic [7:0] b_IN,
    input  logic       carry_IN,
    input  logic [2:0] op_SEL,
    input  logic       decimal_EN,
    input  logic       decimalSub_EN,
    input  logic       start,
    output logic [7:0] adderHold_OUT,
    output logic       carry_OUT,
    output logic       overflow_OUT,
    output logic       halfCarry_OUT,
    output logic       busy,
    output logic       valid
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CORRECT = 1'b1
    } state_t;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd2;
    localparam logic [2:0] OP_EOR = 3'd3;
    localparam logic [2:0] OP_SR  = 3'd4;

    state_t     state_reg;
    state_t     state_next;

    logic [7:0] result_reg;
    logic       carry_reg;
    logic       overflow_reg;
    logic       half_carry_reg;
    logic       valid_reg;

    // Binary result parked while the BCD correction is pending.
    logic [7:0] hold_result_reg;
    logic       hold_carry_reg;
    logic       hold_overflow_reg;
    logic       hold_half_reg;
    logic       hold_sub_reg;

    // Binary stage signals
    logic [8:0] sum_full;
    logic [4:0] low_sum;
    logic [7:0] and_bits;
    logic [7:0] or_bits;
    logic [7:0] eor_bits;
    logic [7:0] bin_result;
    logic       bin_carry;
    logic       bin_overflow;
    logic       bin_half;
    logic       is_sum;
    logic       decimal_req;
    logic       accept;

    // Correction stage signals
    logic [7:0] corr_step;
    logic [7:0] corr_result;
    logic       corr_carry;

    assign sum_full = {1'b0, a_IN} + {1'b0, b_IN} + {8'b0, carry_IN};
    assign low_sum  = {1'b0, a_IN[3:0]} + {1'b0, b_IN[3:0]} + {4'b0, carry_IN};

    // Per-bit logic unit
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_logic_bit
            assign and_bits[gi] = a_IN[gi] & b_IN[gi];
            assign or_bits[gi]  = a_IN[gi] | b_IN[gi];
            assign eor_bits[gi] = a_IN[gi] ^ b_IN[gi];
        end
    endgenerate

    // Reserved encodings 5-7 are handled as SUM, decimal correction included.
    assign is_sum      = (op_SEL == OP_SUM) || (op_SEL > OP_SR);
    assign decimal_req = is_sum && decimal_EN;
    assign accept      = start && (state_reg == ST_IDLE);

    // Binary result and flags for the selected operation
    always_comb begin
        bin_result   = sum_full[7:0];
        bin_carry    = sum_full[8];
        bin_overflow = (a_IN[7] == b_IN[7]) && (sum_full[7] != a_IN[7]);
        bin_half     = low_sum[4];
        case (op_SEL)
            OP_AND: begin
                bin_result   = and_bits;
                bin_carry    = 1'b0;
                bin_overflow = 1'b0;
                bin_half     = 1'b0;
            end
            OP_OR: begin
                bin_result   = or_bits;
                bin_carry    = 1'b0;
                bin_overflow = 1'b0;
                bin_half     = 1'b0;
            end
            OP_EOR: begin
                bin_result   = eor_bits;
                bin_carry    = 1'b0;
                bin_overflow = 1'b0;
                bin_half     = 1'b0;
            end
            OP_SR: begin
                bin_result   = {carry_IN, a_IN[7:1]};
                bin_carry    = a_IN[0];
                bin_overflow = 1'b0;
                bin_half     = 1'b0;
            end
            default: begin
                // SUM path already assigned above
            end
        endcase
    end

    // BCD correction of the parked binary result
    always_comb begin
        corr_step   = hold_result_reg;
        corr_result = hold_result_reg;
        corr_carry  = hold_carry_reg;
        if (hold_sub_reg) begin
            // Subtract: a missing borrow-free nibble means that digit wrapped.
            corr_step   = hold_half_reg  ? hold_result_reg : (hold_result_reg - 8'h06);
            corr_result = hold_carry_reg ? corr_step       : (corr_step - 8'h60);
        end else begin
            corr_step = ((hold_result_reg[3:0] > 4'd9) || hold_half_reg)
                        ? (hold_result_reg + 8'h06) : hold_result_reg;
            // High digit is tested after the low-digit adjustment has rippled in.
            if ((corr_step[7:4] > 4'd9) || hold_carry_reg) begin
                corr_result = corr_step + 8'h60;
                corr_carry  = 1'b1;
            end else begin
                corr_result = corr_step;
            end
        end
    end

    // Next-state logic: only a decimal SUM leaves IDLE, CORRECT lasts one cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && decimal_req) begin
                    state_next = ST_CORRECT;
                end
            end
            ST_CORRECT: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register, adder hold register, flags and the parked binary result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= ST_IDLE;
            result_reg        <= 8'h00;
            carry_reg         <= 1'b0;
            overflow_reg      <= 1'b0;
            half_carry_reg    <= 1'b0;
            valid_reg         <= 1'b0;
            hold_result_reg   <= 8'h00;
            hold_carry_reg    <= 1'b0;
            hold_overflow_reg <= 1'b0;
            hold_half_reg     <= 1'b0;
            hold_sub_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            valid_reg <= 1'b0;
            if (state_reg == ST_CORRECT) begin
                // Any start arriving now is dropped.
                result_reg     <= corr_result;
                carry_reg      <= corr_carry;
                overflow_reg   <= hold_overflow_reg;
                half_carry_reg <= hold_half_reg;
                valid_reg      <= 1'b1;
            end else if (accept) begin
                if (decimal_req) begin
                    hold_result_reg   <= bin_result;
                    hold_carry_reg    <= bin_carry;
                    hold_overflow_reg <= bin_overflow;
                    hold_half_reg     <= bin_half;
                    hold_sub_reg      <= decimalSub_EN;
                end else begin
                    result_reg     <= bin_result;
                    carry_reg      <= bin_carry;
                    overflow_reg   <= bin_overflow;
                    half_carry_reg <= bin_half;
                    valid_reg      <= 1'b1;
                end
            end
        end
    end

    assign adderHold_OUT = result_reg;
    assign carry_OUT     = carry_reg;
    assign overflow_OUT  = overflow_reg;
    assign halfCarry_OUT = half_carry_reg;
    assign busy          = (state_reg == ST_CORRECT);
    assign valid         = valid_reg;

endmodule

// File: tb/tb_alu_adder_hold.sv
// Directed table-driven bench for alu_adder_hold, plus hand-written
// sequences for back-to-back, busy collision and reset corner cases.
module tb_alu_adder_hold;

    logic       clk;
    logic       rst;
    logic [7:0] a_IN;
    logic [7:0] b_IN;
    logic       carry_IN;
    logic [2:0] op_SEL;
    logic       decimal_EN;
    logic       decimalSub_EN;
    logic       start;
    logic [7:0] adderHold_OUT;
    logic       carry_OUT;
    logic       overflow_OUT;
    logic       halfCarry_OUT;
    logic       busy;
    logic       valid;

    int checks = 0;
    int errors = 0;
    logic [7:0] prev_result;

    alu_adder_hold dut (
        .clk           (clk),
        .rst           (rst),
        .a_IN          (a_IN),
        .b_IN          (b_IN),
        .carry_IN      (carry_IN),
        .op_SEL        (op_SEL),
        .decimal_EN    (decimal_EN),
        .decimalSub_EN (decimalSub_EN),
        .start         (start),
        .adderHold_OUT (adderHold_OUT),
        .carry_OUT     (carry_OUT),
        .overflow_OUT  (overflow_OUT),
        .halfCarry_OUT (halfCarry_OUT),
        .busy          (busy),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       dec;
        logic       dsub;
        logic       two_cyc;
        logic [7:0] res;
        logic       ec;
        logic       ev;
        logic       eh;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [0:NVEC-1];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %02h required %02h", name, act, req);
        end
    endtask

    task automatic drive_start(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic dec, input logic dsub);
        op_SEL        = op;
        a_IN          = a;
        b_IN          = b;
        carry_IN      = c;
        decimal_EN    = dec;
        decimalSub_EN = dsub;
        start         = 1'b1;
    endtask

    task automatic scramble_inputs();
        start         = 1'b0;
        a_IN          = 8'($urandom);
        b_IN          = 8'($urandom);
        carry_IN      = 1'($urandom);
        op_SEL        = 3'($urandom);
        decimal_EN    = 1'($urandom);
        decimalSub_EN = 1'($urandom);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        drive_start(v.op, v.a, v.b, v.c, v.dec, v.dsub);
        @(negedge clk);
        scramble_inputs();
        if (v.two_cyc) begin
            check($sformatf("v%0d busy", idx), {7'b0, busy}, 8'h01);
            check($sformatf("v%0d valid_early", idx), {7'b0, valid}, 8'h00);
            check($sformatf("v%0d hold_during_busy", idx), adderHold_OUT, prev_result);
            @(negedge clk);
        end
        check($sformatf("v%0d valid", idx), {7'b0, valid}, 8'h01);
        check($sformatf("v%0d busy_done", idx), {7'b0, busy}, 8'h00);
        check($sformatf("v%0d result", idx), adderHold_OUT, v.res);
        check($sformatf("v%0d carry", idx), {7'b0, carry_OUT}, {7'b0, v.ec});
        check($sformatf("v%0d overflow", idx), {7'b0, overflow_OUT}, {7'b0, v.ev});
        check($sformatf("v%0d halfcarry", idx), {7'b0, halfCarry_OUT}, {7'b0, v.eh});
        $display("vec %0d: op=%0d a=%02h b=%02h c=%0b dec=%0b sub=%0b -> %02h C=%0b V=%0b H=%0b",
                 idx, v.op, v.a, v.b, v.c, v.dec, v.dsub, adderHold_OUT, carry_OUT,
                 overflow_OUT, halfCarry_OUT);
        @(negedge clk);
        check($sformatf("v%0d valid_single", idx), {7'b0, valid}, 8'h00);
        check($sformatf("v%0d result_held", idx), adderHold_OUT, v.res);
        prev_result = v.res;
    endtask

    initial begin
        //             op    a      b      c     dec   dsub  2cyc  res    C     V     H
        vecs[0]  = '{3'd0, 8'h50, 8'h50, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{3'd1, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd3, 8'hFF, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd2, 8'h12, 8'h84, 1'b1, 1'b0, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd4, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'd4, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'd0, 8'h09, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'd0, 8'h10, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'd0, 8'h00, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{3'd5, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 8'h31, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{3'd7, 8'h15, 8'h27, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{3'd0, 8'h08, 8'h08, 1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{3'd0, 8'h50, 8'h50, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{3'd1, 8'hFF, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{3'd0, 8'h90, 8'h90, 1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        scramble_inputs();
        prev_result = 8'h00;
        @(negedge clk);
        @(negedge clk);
        check("reset_result", adderHold_OUT, 8'h00);
        check("reset_flags", {5'b0, carry_OUT, overflow_OUT, halfCarry_OUT}, 8'h00);
        check("reset_busy_valid", {6'b0, busy, valid}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Back-to-back binary starts: one completion per cycle
        @(negedge clk);
        drive_start(3'd1, 8'hF0, 8'h3C, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive_start(3'd2, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
        check("b2b_valid1", {7'b0, valid}, 8'h01);
        check("b2b_result1", adderHold_OUT, 8'h30);
        @(negedge clk);
        scramble_inputs();
        check("b2b_valid2", {7'b0, valid}, 8'h01);
        check("b2b_result2", adderHold_OUT, 8'h03);
        @(negedge clk);
        check("b2b_idle", {7'b0, valid}, 8'h00);
        $display("seq back_to_back: results 30 then 03");

        // Busy collision: second start during CORRECT is dropped
        @(negedge clk);
        drive_start(3'd0, 8'h09, 8'h01, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive_start(3'd0, 8'h33, 8'h11, 1'b0, 1'b0, 1'b0);
        check("coll_busy", {7'b0, busy}, 8'h01);
        check("coll_no_early_valid", {7'b0, valid}, 8'h00);
        check("coll_hold", adderHold_OUT, 8'h03);
        @(negedge clk);
        scramble_inputs();
        check("coll_valid", {7'b0, valid}, 8'h01);
        check("coll_result", adderHold_OUT, 8'h10);
        @(negedge clk);
        check("coll_single_valid", {7'b0, valid}, 8'h00);
        check("coll_result_kept", adderHold_OUT, 8'h10);
        $display("seq busy_collision: result %02h", adderHold_OUT);

        // Reset out of a nonzero result with flags set
        @(negedge clk);
        drive_start(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        scramble_inputs();
        check("pre_rst_carry", {7'b0, carry_OUT}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_result", adderHold_OUT, 8'h00);
        check("rst_flags", {5'b0, carry_OUT, overflow_OUT, halfCarry_OUT}, 8'h00);
        check("rst_valid", {7'b0, valid}, 8'h00);
        $display("seq reset_after_result: result %02h", adderHold_OUT);

        // Reset while in CORRECT aborts with no valid pulse
        @(negedge clk);
        drive_start(3'd0, 8'h99, 8'h01, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        scramble_inputs();
        check("abort_busy", {7'b0, busy}, 8'h01);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy_clear", {7'b0, busy}, 8'h00);
        check("abort_no_valid", {7'b0, valid}, 8'h00);
        check("abort_result", adderHold_OUT, 8'h00);
        check("abort_flags", {5'b0, carry_OUT, overflow_OUT, halfCarry_OUT}, 8'h00);
        @(negedge clk);
        check("abort_no_late_valid", {7'b0, valid}, 8'h00);
        check("abort_idle", {7'b0, busy}, 8'h00);
        $display("seq reset_in_correct: busy=%0b valid=%0b", busy, valid);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_adder_hold.md
# alu_adder_hold

Sequential 6502 ALU core with its adder hold register. It sits directly downstream of the A and B ALU input registers: it consumes their 8-bit outputs and the carry-in. It performs one of five operations and latches the result plus carry, overflow and half-carry flags into the adder hold register. Binary operations complete in one cycle. Decimal-mode sums take a second BCD correction cycle.

## Interface
- No parameters; all widths fixed at 8 bits.
- clk  input  1  single system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- a_IN  input  8  operand A, from A input register output
- b_IN  input  8  operand B, from B input register (already inverted upstream for subtract)
- carry_IN  input  1  carry into bit 0 (SUM) or into bit 7 (SR)
- op_SEL  input  3  0=SUM, 1=AND, 2=OR, 3=EOR, 4=SR; 5-7 reserved, treated as SUM
- decimal_EN  input  1  BCD correction for SUM
- decimalSub_EN  input  1  with decimal_EN: apply subtract correction instead of add correction
- start  input  1  one-cycle request; operands and controls sampled on this edge
- adderHold_OUT  output  8  adder hold register
- carry_OUT  output  1  registered carry flag
- overflow_OUT  output  1  registered signed-overflow flag
- halfCarry_OUT  output  1  registered carry out of bit 3
- busy  output  1  high while a decimal correction is pending
- valid  output  1  one-cycle pulse when adderHold_OUT/flags are updated

## Operation
- State machine: IDLE and CORRECT.
  - IDLE + start + (SUM with decimal_EN) -> CORRECT.
  - CORRECT -> IDLE unconditionally.
  - Every other start is completed within IDLE.
- SUM: 9-bit sum = a_IN + b_IN + carry_IN.
  - halfCarry = carry out of (a_IN[3:0] + b_IN[3:0] + carry_IN).
  - carry = sum bit 8.
  - overflow = (a_IN[7] == b_IN[7]) && (sum[7] != a_IN[7]).
- AND/OR/EOR: bitwise result; carry, overflow and halfCarry all 0.
- SR: result = {carry_IN, a_IN[7:1]}; carry = a_IN[0]; overflow = 0; halfCarry = 0.
- Decimal add correction, done in CORRECT on the held binary result R, flags C/H:
  - If R[3:0] > 9 or H, add 0x06.
  - Then if high nibble > 9 or C, add 0x60 and set C = 1.
  - Result is mod 256.
- Decimal subtract correction (decimalSub_EN):
  - If !H, subtract 0x06.
  - If !C, subtract 0x60.
  - C unchanged; result mod 256.
- Overflow and halfCarry are taken from the binary stage and are not altered by correction.
- A start that arrives while busy is ignored: no queueing, no effect on the current result.
- Reserved op_SEL values 5-7 behave exactly as SUM, including decimal correction.

## Timing
- Reset values (on the rising edge with rst high): state IDLE, adderHold_OUT=0x00, all flags 0, busy=0, valid=0. rst has priority over start.
- Reset asserted in CORRECT aborts the operation. No valid pulse is produced for it.
- Binary path: start sampled at edge N.
  - adderHold_OUT and flags update at edge N.
  - valid is high for the cycle following edge N.
- Decimal path: start sampled at edge N.
  - Binary result is held internally; busy is high for the cycle after edge N.
  - Corrected result and flags update at edge N+1, with valid high for that following cycle.
  - Outputs are not updated with the intermediate binary value.
- adderHold_OUT and flags hold their values between completions.
- valid is never high for two consecutive cycles from a single start.
- Back-to-back binary starts complete one per cycle.
- A start coincident with the CORRECT cycle is dropped.
- Operand inputs may change freely after the sampling edge.

## Test plan
- Reset: drive arbitrary state, assert rst one cycle -> adderHold_OUT=0x00, flags 0, busy=0, valid=0. Assert rst during CORRECT -> no valid pulse, IDLE.
- Binary SUM: a=0x50, b=0x50, c=0 -> 0xA0, V=1, C=0, H=0, valid one cycle after start. a=0xFF, b=0x01, c=0 -> 0x00, C=1, H=1, V=0.
- Logic and shift: AND 0xF0&0x3C -> 0x30, C=0. EOR 0xFF^0x0F -> 0xF0. SR a=0x81, c=1 -> 0xC0, C=1.
- Decimal add: 0x09+0x01, c=0 -> busy one cycle, then 0x10, C=0. 0x99+0x01 -> 0x00, C=1. adderHold_OUT unchanged during busy.
- Decimal subtract: a=0x10, b=0xFE, c=1, decimalSub_EN=1 -> 0x09, C=1. a=0x00, b=0xFE, c=1 -> 0x99, C=0.
- Busy collision: decimal start, then a SUM start on the next cycle -> second start ignored; single valid pulse carries the decimal result.
